// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drain stage for the synchronous FIFO. When the FIFO is not empty, it pops
// one word and sends it as an asynchronous UART frame on a single line. The
// frame is a start bit, the data bits LSB first, an optional parity bit, and
// then the stop bit(s).
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert a parity bit
// after the data bits. PARITY_ODD selects even (0) or odd (1) parity. In the
// default build (macro undefined) there is no parity bit and PARITY_ODD has
// no effect.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   tx_enable   1 = may start new frames; 0 = finish the current frame, then idle
//   fifo_empty  FIFO Empty flag
//   fifo_data   FIFO data_out (registered, valid the cycle after a pop)
//   fifo_rd_en  single-cycle FIFO pop request
//   tx          serial line, idle high
//   busy        high from word capture to the end of the last stop bit
//   tx_done     single-cycle pulse in the last clock of the last stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q,  state_d;
  logic [BAUD_W-1:0] baud_q,   baud_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [WIDTH-1:0]  shift_q,  shift_d;
  logic              parity_q, parity_d;
  logic              rd_en_q,  rd_en_d;
  logic              tx_q,     tx_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              baud_tick;

  // Next-state and datapath logic.
  // The line outputs (tx, busy, tx_done) are decoded from the current state
  // and then registered, so the line lags the FSM by exactly one clock. This
  // lag gives the three-edge start latency and the three idle clocks between
  // back-to-back frames. fifo_rd_en is decoded from the next state so that it
  // is high during the FETCH cycle itself. Then the registered FIFO data is
  // valid during LOAD, when it is captured.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    baud_tick = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_enable && !fifo_empty) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end

      FETCH: state_d = LOAD;

      LOAD: begin
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ ODD;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = START;
      end

      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_q == LOAD)  || (state_q == START) || (state_q == DATA) ||
             (state_q == PARITY) || (state_q == STOP);
  end

  // State and output registers.
  // On reset the line returns high at once. Any partly sent word is dropped,
  // and it is not popped again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      rd_en_q  <= rd_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Scoreboard bench for fifo_uart_tx.
// A behavioural FIFO model feeds the DUT. Each word pushed into the FIFO also
// pushes its expected frame contents into a queue. An independent monitor
// decodes every frame seen on tx, pops the queue and compares the two.
// The main process runs the directed scenarios and checks the counters and
// timing around them.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int WIDTH     = 8;
  localparam int CPB       = 4;
  localparam int STOP_BITS = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       tx_enable  = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  typedef struct packed {
    logic [7:0] word;
    logic       par;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] vec_words [0:15];
  int         vec_wr      = 0;
  int         vec_rd      = 0;
  int         cyc         = 0;
  int         rd_pulses   = 0;
  int         done_pulses = 0;
  int         underflows  = 0;
  int         mon_frames  = 0;
  int         last_gap    = 0;
  int         end_cyc     = -1;
  int         errors      = 0;
  int         checks      = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (STOP_BITS),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // FIFO model: registered data_out, with Empty updated on each clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && (vec_rd < vec_wr)) begin
      fifo_data  <= vec_words[vec_rd];
      vec_rd     <= vec_rd + 1;
      fifo_empty <= ((vec_rd + 1) >= vec_wr);
    end else begin
      fifo_empty <= (vec_rd >= vec_wr);
    end
  end

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      if (fifo_empty) underflows++;
    end
    if (tx_done) done_pulses++;
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] w, input logic p);
    vec_words[vec_wr] = w;
    exp_q.push_back('{word: w, par: p});
    vec_wr++;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (mon_frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output($sformatf("frames_reach_%0d", n), 32'(mon_frames >= n), 32'd1);
  endtask

  task automatic wait_tx_low(input int budget);
    int k;
    k = 0;
    while (tx !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output("start_seen", {31'd0, tx}, 32'd0);
  endtask

  // Monitor: decodes each frame by sampling the middle of every bit.
  initial begin : monitor
    logic [NBITS-1:0] bits;
    exp_t             e;
    logic             have;
    logic             abort;
    int               sc;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || tx !== 1'b0) continue;
      sc = cyc;
      if (end_cyc >= 0) last_gap = sc - end_cyc;
      have = (exp_q.size() > 0);
      e    = '0;
      if (have) e = exp_q.pop_front();
      abort = 1'b0;
      bits  = '0;
      for (int b = 0; b < NBITS; b++) begin
        repeat ((b == 0) ? 2 : CPB) @(negedge clk);
        if (reset !== 1'b1) begin
          abort = 1'b1;
          break;
        end
        bits[b] = tx;
      end
      if (!abort) begin
        @(negedge clk);
        if (reset !== 1'b1) abort = 1'b1;
      end
      if (abort) begin
        end_cyc = -1;
        continue;
      end
      check_output("frame_expected", {31'd0, have}, 32'd1);
      check_output("start_bit", {31'd0, bits[0]}, 32'd0);
      check_output("data_word", {24'd0, bits[8:1]}, {24'd0, e.word});
`ifdef FIFO_UART_TX_PARITY_EN
      check_output("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
`endif
      check_output("stop_bit", {31'd0, bits[NBITS-1]}, 32'd1);
      check_output("last_stop_cycle", {29'd0, tx, busy, tx_done}, 32'b111);
      @(negedge clk);
      check_output("after_frame", {29'd0, tx, busy, tx_done}, 32'b100);
      end_cyc = cyc;
      mon_frames++;
    end
  end

  // Directed scenarios.
  initial begin : main
    int bad;
    reset     = 1'b0;
    tx_enable = 1'b1;

    // Reset held while the FIFO already holds a word.
    apply_stimulus(8'hA5, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_output("reset_hold", {28'd0, tx, fifo_rd_en, busy, tx_done}, 32'b1000);
    end
    reset = 1'b1;

    // A single word 0xA5.
    wait_frames(1, 80);
    check_output("a5_rd_pulses", rd_pulses, 32'd1);
    check_output("a5_done_pulses", done_pulses, 32'd1);

    // Back-to-back words 0x00 and 0xFF.
    apply_stimulus(8'h00, 1'b0);
    apply_stimulus(8'hFF, 1'b0);
    wait_frames(3, 200);
    check_output("b2b_gap", last_gap, 32'd3);
    check_output("b2b_rd_pulses", rd_pulses, 32'd3);
    check_output("b2b_done_pulses", done_pulses, 32'd3);

    // tx_enable dropped mid-frame with 0x11 queued.
    apply_stimulus(8'h3C, 1'b0);
    wait_tx_low(20);
    repeat (20) @(negedge clk);
    tx_enable = 1'b0;
    apply_stimulus(8'h11, 1'b0);
    wait_frames(4, 100);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    check_output("disabled_hold_idle", bad, 32'd0);
    check_output("disabled_rd_pulses", rd_pulses, 32'd4);
    tx_enable = 1'b1;
    @(negedge clk);
    check_output("fetch_pulse_on", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    check_output("fetch_pulse_off", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    check_output("latency_still_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check_output("latency_start_low", {31'd0, tx}, 32'd0);
    wait_frames(5, 100);
    check_output("resume_rd_pulses", rd_pulses, 32'd5);

    // Reset asserted during data bit 3.
    apply_stimulus(8'h96, 1'b0);
    wait_tx_low(20);
    repeat (17) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset_mid_frame", {30'd0, tx, busy}, 32'b10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
    end
    check_output("post_reset_idle", bad, 32'd0);
    check_output("post_reset_rd_pulses", rd_pulses, 32'd6);
    check_output("post_reset_done_pulses", done_pulses, 32'd5);

    // Word 0x07: its even parity bit is 1.
    apply_stimulus(8'h07, 1'b1);
    wait_frames(6, 100);
    check_output("w07_rd_pulses", rd_pulses, 32'd7);
    check_output("w07_done_pulses", done_pulses, 32'd6);

    check_output("no_underflow", underflows, 32'd0);
    check_output("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
